alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Execute-entry stage directly upstream of the ALU.
- Holds the 32x32 register unit and selects the A/B operands: rs1 or PC for A, rs2 or immediate for B.
- Registers A, B and ALUOp behind a valid/ready pipeline register; the ALU consumes these combinationally.
- Write-back enters through a dedicated write port with same-cycle bypass.

Parameters:
- XLEN, 32, data/operand width
- NREGS, 32, architectural registers (index width = $clog2(NREGS))
- SP_INIT, 32'h0000_3FFC, reset value of x2; used only with RU_SP_INIT_EN

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept
- rs1  in  5  source register 1 index
- rs2  in  5  source register 2 index
- rd  in  5  destination index, passed through
- Imm  in  XLEN  sign-extended immediate
- PC  in  XLEN  instruction address
- ALUASrc  in  1  0: A=rs1 data, 1: A=PC
- ALUBSrc  in  1  0: B=rs2 data, 1: B=Imm
- ALUOpIn  in  4  ALU opcode, passed through unchanged
- flush  in  1  kill held/incoming operation
- RUWr  in  1  write-back enable
- rd_wb  in  5  write-back index
- DataWr  in  XLEN  write-back data
- A  out  XLEN  registered ALU operand A
- B  out  XLEN  registered ALU operand B
- ALUOp  out  4  registered ALU opcode
- rd_out  out  5  registered destination
- out_valid  out  1  A/B/ALUOp valid
- out_ready  in  1  downstream accepts

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; A, B, ALUOp, rd_out=0.
  - All registers x0..x31 = 0 (see optional feature for x2).
  - in_ready=1 once reset is released.
- Register unit:
  - Reads are combinational. Index 0 always reads 0.
  - Write occurs on the clk edge when RUWr=1 and rd_wb!=0. Writes to x0 are ignored.
- Bypass: in the same cycle, RUWr=1 and rd_wb==rs1 (or rs2), with the index !=0, makes the read return DataWr, not the stale register value.
- Operand mux:
  - A = ALUASrc ? PC : R[rs1]
  - B = ALUBSrc ? Imm : R[rs2]
  - Mux outputs are captured into the pipeline register.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Load when in_valid && in_ready: A/B/ALUOp/rd_out update and out_valid=1 next cycle.
  - When out_valid && out_ready && !(in_valid && in_ready): out_valid=0 next cycle.
  - Held outputs are stable while out_valid && !out_ready.
- Latency: 1 cycle, input accept to out_valid. Throughput: 1 op/cycle when out_ready is held at 1.
- flush=1: out_valid=0 next cycle regardless of handshake. Flush beats a simultaneous load; the data registers may update but are don't-care. Register-unit writes still occur during flush.
- Write-back is independent of the handshake; it is accepted every cycle, including during stall.
- Mid-operation reset clears out_valid immediately; any in-flight op is lost.

Optional Feature:
- Macro: RU_SP_INIT_EN.
- Defined: x2 resets to SP_INIT; all other registers reset to 0.
- Undefined: x2 resets to 0 like every other register; SP_INIT is unused.

Decomposition:
- Shared package (cpu_pkg) holds:
  - XLEN and REG_IDX_W localparams
  - typedef alu_op_t (logic [3:0])
  - ALU opcode constants: ADD=4'b0000, SUB=4'b1000, SLT=4'b0010, SLTU=4'b0011, SLL=4'b0001, XOR=4'b0100, SRL=4'b0101, SRA=4'b1101, OR=4'b0110, AND=4'b0111
- One natural sub-module, register_unit:
  - 2 combinational read ports, 1 write port, bypass, x0 hardwiring, reset/SP init.
  - alu_operand_stage instantiates it and adds the muxes and pipeline register.

Test Plan:
- Reset, then write x5=32'h0000_0010 and x6=32'h0000_0003; issue rs1=5, rs2=6, ALUASrc=0, ALUBSrc=0, ALUOpIn=4'b1000 -> next cycle out_valid=1, A=16, B=3, ALUOp=4'b1000.
- Same cycle RUWr=1, rd_wb=7, DataWr=32'hDEAD_BEEF and rs1=7 -> A=32'hDEAD_BEEF (bypass); write rd_wb=0, DataWr=5, then read rs1=0 -> A=0.
- ALUASrc=1, PC=32'h0000_0040, ALUBSrc=1, Imm=32'hFFFF_FFFC -> A=32'h40, B=32'hFFFF_FFFC.
- out_ready=0 with out_valid=1 and a new in_valid -> in_ready=0, A/B unchanged for 3 cycles; raise out_ready -> new op loaded next cycle, back-to-back ops at 1/cycle.
- flush=1 in the same cycle as an accepted in_valid -> out_valid=0 next cycle; a concurrent write-back still lands in the register unit.
- Assert rst_n=0 mid-stall -> out_valid=0 immediately (without clk); with RU_SP_INIT_EN defined, rs1=2 reads 32'h0000_3FFC after reset, and 0 without it.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU definitions: datapath width, register-index width,
//            ALU opcode type and the ALU opcode encodings.
// Ports    : none (package)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [3:0] alu_op_t;

  // Bit 3 selects the "alternate" form (SUB vs ADD, SRA vs SRL).
  localparam alu_op_t ADD  = 4'b0000;
  localparam alu_op_t SUB  = 4'b1000;
  localparam alu_op_t SLT  = 4'b0010;
  localparam alu_op_t SLTU = 4'b0011;
  localparam alu_op_t SLL  = 4'b0001;
  localparam alu_op_t XOR  = 4'b0100;
  localparam alu_op_t SRL  = 4'b0101;
  localparam alu_op_t SRA  = 4'b1101;
  localparam alu_op_t OR   = 4'b0110;
  localparam alu_op_t AND  = 4'b0111;

endpackage

`default_nettype wire

// File: rtl/register_unit.sv
// ============================================================================
// Module   : register_unit
// Purpose  : NREGS x XLEN architectural register file. Two combinational
//            read ports with same-cycle write-back bypass, one synchronous
//            write port, x0 hardwired to zero.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            raddr1_i / rdata1_o   - read port 1 index / data
//            raddr2_i / rdata2_o   - read port 2 index / data
//            we_i, waddr_i, wdata_i - write-back enable, index, data
// Options  : RU_SP_INIT_EN - when defined, x2 resets to SP_INIT instead of 0
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_unit #(
  parameter int              XLEN    = 32,
  parameter int              NREGS   = 32,
  parameter logic [XLEN-1:0] SP_INIT = 32'h0000_3FFC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] raddr1_i,
  input  logic [$clog2(NREGS)-1:0] raddr2_i,
  output logic [XLEN-1:0]          rdata1_o,
  output logic [XLEN-1:0]          rdata2_o,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [XLEN-1:0]          wdata_i
);
  import cpu_pkg::*;

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  // Writes to x0 are dropped so entry 0 never leaves its reset value.
  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
`ifdef RU_SP_INIT_EN
      regs_q[2] <= SP_INIT;
`endif
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

`ifndef RU_SP_INIT_EN
  // SP_INIT has no effect in this build; fold it into a sink signal.
  logic unused_sp_init;
  assign unused_sp_init = ^SP_INIT;
`endif

  // x0 reads zero first; otherwise a same-cycle write to the same index
  // forwards the incoming data ahead of the stale stored value.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (wr_en && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (wr_en && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : Execute-entry stage in front of the ALU. Reads rs1/rs2 from the
//            register unit, selects A (rs1 data or PC) and B (rs2 data or
//            immediate), and registers A/B/ALUOp/rd behind a valid/ready
//            pipeline register. Write-back enters via a dedicated port.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            in_valid/in_ready          - upstream handshake
//            rs1, rs2, rd, Imm, PC      - decoded operand sources
//            ALUASrc, ALUBSrc, ALUOpIn  - operand selects and ALU opcode
//            flush                      - kill held/incoming operation
//            RUWr, rd_wb, DataWr        - register write-back port
//            A, B, ALUOp, rd_out        - registered ALU operands
//            out_valid/out_ready        - downstream handshake
// Options  : RU_SP_INIT_EN - x2 resets to SP_INIT (see register_unit)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_stage #(
  parameter int              XLEN    = 32,
  parameter int              NREGS   = 32,
  parameter logic [XLEN-1:0] SP_INIT = 32'h0000_3FFC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [XLEN-1:0]          Imm,
  input  logic [XLEN-1:0]          PC,
  input  logic                     ALUASrc,
  input  logic                     ALUBSrc,
  input  logic [3:0]               ALUOpIn,
  input  logic                     flush,
  input  logic                     RUWr,
  input  logic [$clog2(NREGS)-1:0] rd_wb,
  input  logic [XLEN-1:0]          DataWr,
  output logic [XLEN-1:0]          A,
  output logic [XLEN-1:0]          B,
  output logic [3:0]               ALUOp,
  output logic [$clog2(NREGS)-1:0] rd_out,
  output logic                     out_valid,
  input  logic                     out_ready
);
  import cpu_pkg::*;

  localparam int IDX_W = $clog2(NREGS);

  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  a_mux;
  logic [XLEN-1:0]  b_mux;
  logic             load;

  logic [XLEN-1:0]  A_q,         A_d;
  logic [XLEN-1:0]  B_q,         B_d;
  alu_op_t          ALUOp_q,     ALUOp_d;
  logic [IDX_W-1:0] rd_q,        rd_d;
  logic             out_valid_q, out_valid_d;

  register_unit #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .SP_INIT (SP_INIT)
  ) u_register_unit (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data),
    .we_i     (RUWr),
    .waddr_i  (rd_wb),
    .wdata_i  (DataWr)
  );

  assign a_mux = ALUASrc ? PC  : rs1_data;
  assign b_mux = ALUBSrc ? Imm : rs2_data;

  // Slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    A_d         = A_q;
    B_d         = B_q;
    ALUOp_d     = ALUOp_q;
    rd_d        = rd_q;
    out_valid_d = out_valid_q;

    if (load) begin
      A_d         = a_mux;
      B_d         = b_mux;
      ALUOp_d     = alu_op_t'(ALUOpIn);
      rd_d        = rd;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Flush wins over a simultaneous load; the data registers may still
    // take the new operands, but they are don't-care while invalid.
    if (flush) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A_q         <= '0;
      B_q         <= '0;
      ALUOp_q     <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      A_q         <= A_d;
      B_q         <= B_d;
      ALUOp_q     <= ALUOp_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign A         = A_q;
  assign B         = B_q;
  assign ALUOp     = ALUOp_q;
  assign rd_out    = rd_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Self-checking bench for alu_operand_stage: table of directed
//            operand vectors plus hand-written stall, flush and
//            mid-operation reset sequences.
// Options  : RU_SP_INIT_EN - changes the expected reset value of x2
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;

`ifdef RU_SP_INIT_EN
  localparam logic [31:0] EXP_X2 = 32'h0000_3FFC;
`else
  localparam logic [31:0] EXP_X2 = 32'h0000_0000;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] Imm, PC;
  logic        ALUASrc, ALUBSrc;
  logic [3:0]  ALUOpIn;
  logic        flush;
  logic        RUWr;
  logic [4:0]  rd_wb;
  logic [31:0] DataWr;
  logic [31:0] A, B;
  logic [3:0]  ALUOp;
  logic [4:0]  rd_out;
  logic        out_valid;
  logic        out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_operand_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .Imm       (Imm),
    .PC        (PC),
    .ALUASrc   (ALUASrc),
    .ALUBSrc   (ALUBSrc),
    .ALUOpIn   (ALUOpIn),
    .flush     (flush),
    .RUWr      (RUWr),
    .rd_wb     (rd_wb),
    .DataWr    (DataWr),
    .A         (A),
    .B         (B),
    .ALUOp     (ALUOp),
    .rd_out    (rd_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        asrc, bsrc;
    logic [31:0] pc, imm;
    logic [3:0]  op;
    logic        wr;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic [31:0] ea, eb;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(
    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
    input logic as, input logic bs, input logic [31:0] p, input logic [31:0] im,
    input logic [3:0] o, input logic w, input logic [4:0] wd, input logic [31:0] wv,
    input logic [31:0] xa, input logic [31:0] xb);
    vec_t v;
    v.rs1 = r1; v.rs2 = r2; v.rd = d; v.asrc = as; v.bsrc = bs;
    v.pc = p; v.imm = im; v.op = o; v.wr = w; v.wrd = wd; v.wdata = wv;
    v.ea = xa; v.eb = xb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic as, input logic bs, input logic [31:0] p,
                       input logic [31:0] im, input logic [3:0] o);
    rs1 = r1; rs2 = r2; rd = d; ALUASrc = as; ALUBSrc = bs;
    PC = p; Imm = im; ALUOpIn = o;
  endtask

  task automatic wb(input logic [4:0] idx, input logic [31:0] data);
    RUWr = 1'b1; rd_wb = idx; DataWr = data;
    tick();
    RUWr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    RUWr = 1'b0; rd_wb = '0; DataWr = '0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Operand vectors; x5=0x10 and x6=3 are written before the table runs.
    vecs[0] = mk(5'd5, 5'd6, 5'd1, 0, 0, 32'h0, 32'h0, 4'b1000, 0, 5'd0, 32'h0,
                 32'h0000_0010, 32'h0000_0003);
    vecs[1] = mk(5'd7, 5'd5, 5'd2, 0, 0, 32'h0, 32'h0, 4'b0000, 1, 5'd7, 32'hDEAD_BEEF,
                 32'hDEAD_BEEF, 32'h0000_0010);
    vecs[2] = mk(5'd0, 5'd0, 5'd3, 0, 0, 32'h0, 32'h0, 4'b0010, 1, 5'd0, 32'h5,
                 32'h0, 32'h0);
    vecs[3] = mk(5'd5, 5'd6, 5'd4, 1, 1, 32'h40, 32'hFFFF_FFFC, 4'b0000, 0, 5'd0, 32'h0,
                 32'h0000_0040, 32'hFFFF_FFFC);
    vecs[4] = mk(5'd7, 5'd7, 5'd5, 0, 0, 32'h0, 32'h0, 4'b0100, 0, 5'd0, 32'h0,
                 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vecs[5] = mk(5'd5, 5'd6, 5'd6, 0, 0, 32'h0, 32'h0, 4'b0110, 1, 5'd6, 32'h55,
                 32'h0000_0010, 32'h0000_0055);
    vecs[6] = mk(5'd6, 5'd9, 5'd7, 0, 1, 32'h0, 32'h7, 4'b0001, 0, 5'd0, 32'h0,
                 32'h0000_0055, 32'h0000_0007);
    vecs[7] = mk(5'd31, 5'd1, 5'd8, 0, 0, 32'h0, 32'h0, 4'b1101, 0, 5'd0, 32'h0,
                 32'h0, 32'h0);
    vecs[8] = mk(5'd2, 5'd2, 5'd31, 0, 0, 32'h0, 32'h0, 4'b0111, 0, 5'd0, 32'h0,
                 EXP_X2, EXP_X2);

    // Reset state
    tick(); tick();
    chk("rst out_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst A", A, 32'h0);
    chk("rst B", B, 32'h0);
    chk("rst ALUOp", {28'b0, ALUOp}, 32'h0);
    chk("rst rd_out", {27'b0, rd_out}, 32'h0);
    chk("rst in_ready", {31'b0, in_ready}, 32'h1);

    wb(5'd5, 32'h0000_0010);
    wb(5'd6, 32'h0000_0003);

    // Back-to-back table vectors, one per cycle with out_ready held high
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].asrc, vecs[i].bsrc,
            vecs[i].pc, vecs[i].imm, vecs[i].op);
      RUWr = vecs[i].wr; rd_wb = vecs[i].wrd; DataWr = vecs[i].wdata;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'h1);
      tick();
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("v%0d A", i), A, vecs[i].ea);
      chk($sformatf("v%0d B", i), B, vecs[i].eb);
      chk($sformatf("v%0d ALUOp", i), {28'b0, ALUOp}, {28'b0, vecs[i].op});
      chk($sformatf("v%0d rd_out", i), {27'b0, rd_out}, {27'b0, vecs[i].rd});
    end
    in_valid = 1'b0; RUWr = 1'b0;

    // Drain
    tick();
    chk("drain out_valid", {31'b0, out_valid}, 32'h0);

    // Stall: hold op with out_ready low while a new op waits
    out_ready = 1'b0;
    drive(5'd5, 5'd6, 5'd12, 0, 0, 32'h0, 32'h0, 4'b0111);
    in_valid = 1'b1;
    tick();
    chk("stall load valid", {31'b0, out_valid}, 32'h1);
    drive(5'd0, 5'd0, 5'd13, 1, 1, 32'h100, 32'h200, 4'b1000);
    RUWr = 1'b1; rd_wb = 5'd10; DataWr = 32'h77;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d in_ready", c), {31'b0, in_ready}, 32'h0);
      tick();
      RUWr = 1'b0;
      chk($sformatf("stall%0d valid", c), {31'b0, out_valid}, 32'h1);
      chk($sformatf("stall%0d A", c), A, 32'h10);
      chk($sformatf("stall%0d B", c), B, 32'h55);
      chk($sformatf("stall%0d ALUOp", c), {28'b0, ALUOp}, 32'h7);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    chk("release A", A, 32'h100);
    chk("release B", B, 32'h200);
    chk("release ALUOp", {28'b0, ALUOp}, 32'h8);
    chk("release rd_out", {27'b0, rd_out}, 32'd13);
    drive(5'd10, 5'd0, 5'd14, 0, 1, 32'h0, 32'h0, 4'b0000);
    tick();
    chk("stall wb A", A, 32'h77);
    chk("stall wb valid", {31'b0, out_valid}, 32'h1);

    // Flush beats a simultaneous accept; write-back still lands
    flush = 1'b1;
    drive(5'd5, 5'd6, 5'd15, 0, 0, 32'h0, 32'h0, 4'b0000);
    RUWr = 1'b1; rd_wb = 5'd11; DataWr = 32'h99;
    tick();
    flush = 1'b0; RUWr = 1'b0;
    chk("flush valid", {31'b0, out_valid}, 32'h0);
    drive(5'd11, 5'd0, 5'd16, 0, 0, 32'h0, 32'h0, 4'b0000);
    tick();
    chk("flush wb A", A, 32'h99);
    chk("post flush valid", {31'b0, out_valid}, 32'h1);

    // Flush of a held op
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush held valid", {31'b0, out_valid}, 32'h0);

    // Asynchronous reset in the middle of a stall
    drive(5'd5, 5'd0, 5'd17, 0, 0, 32'h0, 32'h0, 4'b0101);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre-rst valid", {31'b0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst valid", {31'b0, out_valid}, 32'h0);
    chk("async rst A", A, 32'h0);
    chk("async rst ALUOp", {28'b0, ALUOp}, 32'h0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(5'd7, 5'd2, 5'd18, 0, 0, 32'h0, 32'h0, 4'b0000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post-rst x7", A, 32'h0);
    chk("post-rst x2", B, EXP_X2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
